return_stack_param: RTL and testbench
=====================================

# return_stack_param

Parametrised hardware return-address stack for the processor's call/return path. Call instructions push the next-PC value (NPPC); return instructions pop the most recent entry into Ret_Add for the fetch stage. The block adds several capabilities: configurable width and depth, push-and-pop in the same cycle, flush, occupancy and full/empty status, a sticky error flag, and an optional circular overwrite mode for deep recursion.

## Interface
Parameters:
- ADDR_W, 13, width of stored return addresses.
- DEPTH, 64, number of entries; power of two, ≥ 2.
- WRAP_MODE, 0. 0 = reject push when full; 1 = circular, a push when full overwrites the oldest entry.
- CNT_W, $clog2(DEPTH+1), width of Stack_Count (derived, not overridden).

Ports (clock and reset first):
- Slow_Clock  in  1  single clock; all state updates on its falling edge.
- Reset  in  1  synchronous, active-high; sampled on the falling edge of Slow_Clock.
- Stack_Push  in  1  push NPPC this edge.
- Stack_Pop  in  1  pop top entry into Ret_Add this edge.
- Stack_Flush  in  1  discard all entries this edge.
- NPPC  in  ADDR_W  address to push.
- Ret_Add  out  ADDR_W  registered popped address.
- Ret_Valid  out  1  one-cycle pulse: Ret_Add was updated by this edge's pop.
- Top_Add  out  ADDR_W  combinational peek of the current top entry; 0 when empty.
- Stack_Count  out  CNT_W  number of valid entries, 0..DEPTH.
- Stack_Full  out  1  Stack_Count == DEPTH (combinational from count register).
- Stack_Empty  out  1  Stack_Count == 0.
- Err_Out  out  1  result of the last push/pop operation: 1 = failed.
- Err_Sticky  out  1  set by any error; cleared only by Reset or Stack_Flush.

## Operation
- State consists of:
  - storage array mem[DEPTH];
  - stack pointer SP, log2(DEPTH) bits, modulo DEPTH, pointing at the next free slot;
  - count register, CNT_W bits.
- Top entry is mem[SP-1], computed mod DEPTH.
- Priority per edge: Reset > Stack_Flush > push/pop.
- Reset:
  - Ret_Add=0, Ret_Valid=0, SP=0, count=0, Err_Out=0, Err_Sticky=0.
  - Hence Stack_Empty=1, Stack_Full=0, Top_Add=0.
  - Memory contents are not cleared.
- Flush: SP=0, count=0, Ret_Valid=0, Err_Out=0, Err_Sticky=0. Ret_Add holds its value; memory is untouched.
- Push only:
  - Not full: mem[SP]=NPPC, SP+1, count+1, Err_Out=0.
  - Full, WRAP_MODE=0: no state change, Err_Out=1, Err_Sticky=1.
  - Full, WRAP_MODE=1: mem[SP]=NPPC (the slot of the oldest entry), SP+1 wrapping, count stays DEPTH, Err_Out=0.
- Pop only:
  - Not empty: Ret_Add=mem[SP-1], SP-1, count-1, Ret_Valid=1, Err_Out=0.
  - Empty: Ret_Add holds, Ret_Valid=0, Err_Out=1, Err_Sticky=1.
- Push and pop together:
  - Not empty: Ret_Add = old top, mem[SP-1]=NPPC (top replaced), SP and count unchanged, Ret_Valid=1, Err_Out=0. Valid when full in either mode.
  - Empty: NPPC is pushed as for push only, Ret_Valid=0, Err_Out=1, Err_Sticky=1.
- Idle (neither push nor pop): Ret_Valid=0; Ret_Add and Err_Out hold.
- In WRAP_MODE=1, popping more than DEPTH times after overwrites hits the empty condition (count reaches 0). Overwritten entries are never returned.

## Timing
- Single-edge latency: an operation sampled on falling edge N is reflected in Ret_Add, Ret_Valid, Stack_Count, Err_Out and Top_Add immediately after edge N.
- Ret_Valid is high for exactly the one cycle following a successful pop edge.
- Back-to-back operations are allowed every cycle; there are no stall or ready signals.
- A push at edge N followed by a pop at edge N+1 returns the pushed NPPC.
- Top_Add is combinational from SP, count and mem. It updates in the same cycle as the state change, with no extra latency.
- Reset or flush asserted alongside push/pop: the push/pop is ignored entirely, with no write to mem.

## Test plan
- Reset, then push 0x0100, 0x0200, 0x0300 → Stack_Count=3, Top_Add=0x0300. Three pops → Ret_Add 0x0300, 0x0200, 0x0100 with Ret_Valid each cycle; Stack_Empty=1.
- Pop on empty stack → Err_Out=1, Err_Sticky=1, Ret_Valid=0, Ret_Add unchanged. Then push 0x0005 → Err_Out=0, Err_Sticky still 1. Then flush → Err_Sticky=0, Stack_Count=0.
- WRAP_MODE=0, DEPTH=4: push 1..5 → fifth push gives Err_Out=1, count=4. Four pops return 4,3,2,1.
- WRAP_MODE=1, DEPTH=4: push 1..6 → count=4, Err_Out=0. Four pops return 6,5,4,3; a fifth pop gives Err_Out=1.
- Push 0x0010, then push+pop with NPPC=0x0020 → Ret_Add=0x0010, Ret_Valid=1, count=1, Top_Add=0x0020. Push+pop on empty with NPPC=0x0030 → count=1, Err_Out=1, Ret_Valid=0.
- Three pushes, then Reset asserted together with Stack_Pop → Ret_Add=0, count=0, Ret_Valid=0, Err_Out=0.

Source files
------------

// File: rtl/return_stack_param.sv
// return_stack_param: parametrised return-address stack for the call/return path.
// Calls push NPPC, returns pop the newest entry into Ret_Add. All state updates
// on the falling edge of Slow_Clock. Supports push+pop replace, flush, status
// flags, a per-operation and a sticky error flag, and an optional circular mode
// where a push on a full stack silently overwrites the oldest entry.
module return_stack_param #(
  parameter int ADDR_W    = 13,
  parameter int DEPTH     = 64,
  parameter int WRAP_MODE = 0,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              Slow_Clock,
  input  logic              Reset,
  input  logic              Stack_Push,
  input  logic              Stack_Pop,
  input  logic              Stack_Flush,
  input  logic [ADDR_W-1:0] NPPC,
  output logic [ADDR_W-1:0] Ret_Add,
  output logic              Ret_Valid,
  output logic [ADDR_W-1:0] Top_Add,
  output logic [CNT_W-1:0]  Stack_Count,
  output logic              Stack_Full,
  output logic              Stack_Empty,
  output logic              Err_Out,
  output logic              Err_Sticky
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  // Architectural state
  logic [ADDR_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  sp_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [ADDR_W-1:0] ret_add_r;
  logic              ret_valid_r;
  logic              err_r;
  logic              sticky_r;

  // Next-state and write-port signals
  logic [PTR_W-1:0]  sp_nxt_s;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic [ADDR_W-1:0] ret_add_nxt_s;
  logic              ret_valid_nxt_s;
  logic              err_nxt_s;
  logic              sticky_nxt_s;
  logic              wr_en_s;
  logic [PTR_W-1:0]  wr_addr_s;

  // Derived status; the top entry sits one below the next-free pointer (mod DEPTH)
  logic [PTR_W-1:0]  top_idx_s;
  logic              empty_s;
  logic              full_s;

  assign top_idx_s = sp_r - PTR_ONE;
  assign empty_s   = (cnt_r == {CNT_W{1'b0}});
  assign full_s    = (cnt_r == CNT_DEPTH);

  assign Ret_Add     = ret_add_r;
  assign Ret_Valid   = ret_valid_r;
  assign Stack_Count = cnt_r;
  assign Stack_Full  = full_s;
  assign Stack_Empty = empty_s;
  assign Err_Out     = err_r;
  assign Err_Sticky  = sticky_r;
  assign Top_Add     = empty_s ? {ADDR_W{1'b0}} : mem_r[top_idx_s];

  // Next-state decode: Reset beats flush, flush beats push/pop
  always_comb begin
    sp_nxt_s        = sp_r;
    cnt_nxt_s       = cnt_r;
    ret_add_nxt_s   = ret_add_r;
    ret_valid_nxt_s = 1'b0;
    err_nxt_s       = err_r;
    sticky_nxt_s    = sticky_r;
    wr_en_s         = 1'b0;
    wr_addr_s       = sp_r;
    if (Reset) begin
      sp_nxt_s      = {PTR_W{1'b0}};
      cnt_nxt_s     = {CNT_W{1'b0}};
      ret_add_nxt_s = {ADDR_W{1'b0}};
      err_nxt_s     = 1'b0;
      sticky_nxt_s  = 1'b0;
    end else if (Stack_Flush) begin
      sp_nxt_s     = {PTR_W{1'b0}};
      cnt_nxt_s    = {CNT_W{1'b0}};
      err_nxt_s    = 1'b0;
      sticky_nxt_s = 1'b0;
    end else if (Stack_Push && Stack_Pop) begin
      if (!empty_s) begin
        // Replace the top in place: return the old one, store NPPC over it
        ret_add_nxt_s   = mem_r[top_idx_s];
        ret_valid_nxt_s = 1'b1;
        wr_en_s         = 1'b1;
        wr_addr_s       = top_idx_s;
        err_nxt_s       = 1'b0;
      end else begin
        // Nothing to return, but the push half still lands
        wr_en_s      = 1'b1;
        sp_nxt_s     = sp_r + PTR_ONE;
        cnt_nxt_s    = cnt_r + CNT_ONE;
        err_nxt_s    = 1'b1;
        sticky_nxt_s = 1'b1;
      end
    end else if (Stack_Push) begin
      if (!full_s) begin
        wr_en_s   = 1'b1;
        sp_nxt_s  = sp_r + PTR_ONE;
        cnt_nxt_s = cnt_r + CNT_ONE;
        err_nxt_s = 1'b0;
      end else if (WRAP_MODE != 0) begin
        // When full, SP points at the oldest entry, so writing there overwrites it
        wr_en_s   = 1'b1;
        sp_nxt_s  = sp_r + PTR_ONE;
        err_nxt_s = 1'b0;
      end else begin
        err_nxt_s    = 1'b1;
        sticky_nxt_s = 1'b1;
      end
    end else if (Stack_Pop) begin
      if (!empty_s) begin
        ret_add_nxt_s   = mem_r[top_idx_s];
        ret_valid_nxt_s = 1'b1;
        sp_nxt_s        = top_idx_s;
        cnt_nxt_s       = cnt_r - CNT_ONE;
        err_nxt_s       = 1'b0;
      end else begin
        err_nxt_s    = 1'b1;
        sticky_nxt_s = 1'b1;
      end
    end else begin
      ret_valid_nxt_s = 1'b0;
    end
  end

  // Control and output registers, synchronous reset on the falling edge
  always_ff @(negedge Slow_Clock) begin
    sp_r        <= sp_nxt_s;
    cnt_r       <= cnt_nxt_s;
    ret_add_r   <= ret_add_nxt_s;
    ret_valid_r <= ret_valid_nxt_s;
    err_r       <= err_nxt_s;
    sticky_r    <= sticky_nxt_s;
  end

  // Storage write port; contents survive Reset and flush
  always_ff @(negedge Slow_Clock) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= NPPC;
    end else begin
      mem_r[wr_addr_s] <= mem_r[wr_addr_s];
    end
  end

endmodule

// File: tb/tb_return_stack_param.sv
// Bench for return_stack_param: three instances (64/reject, 4/reject, 4/wrap)
// share one stimulus stream; each is tracked by a simple array-of-entries model.
module tb_return_stack_param;

  logic        clk = 1'b1;
  logic        reset = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic        flush = 1'b0;
  logic [12:0] nppc = 13'd0;

  logic [12:0] ret_a [3];
  logic [12:0] top_a [3];
  logic        val_a [3];
  logic        full_a [3];
  logic        empty_a [3];
  logic        err_a [3];
  logic        st_a [3];
  logic [6:0]  cnt0;
  logic [2:0]  cnt1, cnt2;
  logic [6:0]  cnt_a [3];

  assign cnt_a[0] = cnt0;
  assign cnt_a[1] = {4'd0, cnt1};
  assign cnt_a[2] = {4'd0, cnt2};

  int n_cmp = 0;
  int n_fail = 0;

  // Model state: entries ms[k][0..mc-1], oldest at index 0
  logic [12:0] ms [3][64];
  int          mc [3];
  logic [12:0] mret [3];
  logic        mval [3];
  logic        merr [3];
  logic        mst [3];
  int          mdepth [3] = '{64, 4, 4};
  int          mwrap [3]  = '{0, 0, 1};

  always #5 clk = ~clk;

  return_stack_param u0 (
    .Slow_Clock(clk), .Reset(reset), .Stack_Push(push), .Stack_Pop(pop),
    .Stack_Flush(flush), .NPPC(nppc), .Ret_Add(ret_a[0]), .Ret_Valid(val_a[0]),
    .Top_Add(top_a[0]), .Stack_Count(cnt0), .Stack_Full(full_a[0]),
    .Stack_Empty(empty_a[0]), .Err_Out(err_a[0]), .Err_Sticky(st_a[0]));

  return_stack_param #(.DEPTH(4), .WRAP_MODE(0)) u1 (
    .Slow_Clock(clk), .Reset(reset), .Stack_Push(push), .Stack_Pop(pop),
    .Stack_Flush(flush), .NPPC(nppc), .Ret_Add(ret_a[1]), .Ret_Valid(val_a[1]),
    .Top_Add(top_a[1]), .Stack_Count(cnt1), .Stack_Full(full_a[1]),
    .Stack_Empty(empty_a[1]), .Err_Out(err_a[1]), .Err_Sticky(st_a[1]));

  return_stack_param #(.DEPTH(4), .WRAP_MODE(1)) u2 (
    .Slow_Clock(clk), .Reset(reset), .Stack_Push(push), .Stack_Pop(pop),
    .Stack_Flush(flush), .NPPC(nppc), .Ret_Add(ret_a[2]), .Ret_Valid(val_a[2]),
    .Top_Add(top_a[2]), .Stack_Count(cnt2), .Stack_Full(full_a[2]),
    .Stack_Empty(empty_a[2]), .Err_Out(err_a[2]), .Err_Sticky(st_a[2]));

  // Apply one operation for one falling edge, advance the model, settle
  task automatic step(input logic r, input logic f, input logic pu, input logic po,
                      input logic [12:0] a);
    reset = r; flush = f; push = pu; pop = po; nppc = a;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        mc[k] = 0; mret[k] = 13'd0; mval[k] = 1'b0; merr[k] = 1'b0; mst[k] = 1'b0;
      end else if (f) begin
        mc[k] = 0; mval[k] = 1'b0; merr[k] = 1'b0; mst[k] = 1'b0;
      end else if (pu && po) begin
        if (mc[k] > 0) begin
          mret[k] = ms[k][mc[k]-1]; ms[k][mc[k]-1] = a; mval[k] = 1'b1; merr[k] = 1'b0;
        end else begin
          ms[k][0] = a; mc[k] = 1; mval[k] = 1'b0; merr[k] = 1'b1; mst[k] = 1'b1;
        end
      end else if (pu) begin
        mval[k] = 1'b0;
        if (mc[k] < mdepth[k]) begin
          ms[k][mc[k]] = a; mc[k]++; merr[k] = 1'b0;
        end else if (mwrap[k] != 0) begin
          for (int i = 0; i < mdepth[k] - 1; i++) ms[k][i] = ms[k][i+1];
          ms[k][mdepth[k]-1] = a; merr[k] = 1'b0;
        end else begin
          merr[k] = 1'b1; mst[k] = 1'b1;
        end
      end else if (po) begin
        if (mc[k] > 0) begin
          mret[k] = ms[k][mc[k]-1]; mc[k]--; mval[k] = 1'b1; merr[k] = 1'b0;
        end else begin
          mval[k] = 1'b0; merr[k] = 1'b1; mst[k] = 1'b1;
        end
      end else begin
        mval[k] = 1'b0;
      end
    end
    #1;
    reset = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 13'd0);
    n_cmp++; if (ret_a[0] !== 13'd0) begin n_fail++; $display("FAIL reset_ret_add got %0h want 0", ret_a[0]); end
    n_cmp++; if (val_a[0] !== 1'b0) begin n_fail++; $display("FAIL reset_ret_valid got %0b want 0", val_a[0]); end
    n_cmp++; if (cnt_a[0] !== 7'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", cnt_a[0]); end
    n_cmp++; if (empty_a[0] !== 1'b1 || full_a[0] !== 1'b0) begin n_fail++; $display("FAIL reset_flags got empty=%0b full=%0b want 1/0", empty_a[0], full_a[0]); end
    n_cmp++; if (top_a[0] !== 13'd0) begin n_fail++; $display("FAIL reset_top got %0h want 0", top_a[0]); end
    n_cmp++; if (err_a[0] !== 1'b0 || st_a[0] !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0b/%0b want 0/0", err_a[0], st_a[0]); end
  endtask

  task automatic test_lifo();
    logic [12:0] exp_v [3] = '{13'h0300, 13'h0200, 13'h0100};
    step(1'b0, 1'b0, 1'b1, 1'b0, 13'h0100);
    step(1'b0, 1'b0, 1'b1, 1'b0, 13'h0200);
    step(1'b0, 1'b0, 1'b1, 1'b0, 13'h0300);
    n_cmp++; if (cnt_a[0] !== 7'd3) begin n_fail++; $display("FAIL lifo_count got %0d want 3", cnt_a[0]); end
    n_cmp++; if (top_a[0] !== 13'h0300) begin n_fail++; $display("FAIL lifo_top got %0h want 300", top_a[0]); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 13'd0);
      n_cmp++; if (ret_a[0] !== exp_v[i] || val_a[0] !== 1'b1) begin n_fail++; $display("FAIL lifo_pop%0d got %0h/%0b want %0h/1", i, ret_a[0], val_a[0], exp_v[i]); end
    end
    n_cmp++; if (empty_a[0] !== 1'b1) begin n_fail++; $display("FAIL lifo_empty got %0b want 1", empty_a[0]); end
  endtask

  task automatic test_error();
    step(1'b0, 1'b0, 1'b0, 1'b1, 13'd0);
    n_cmp++; if (err_a[0] !== 1'b1 || st_a[0] !== 1'b1) begin n_fail++; $display("FAIL underflow_err got %0b/%0b want 1/1", err_a[0], st_a[0]); end
    n_cmp++; if (val_a[0] !== 1'b0 || ret_a[0] !== 13'h0100) begin n_fail++; $display("FAIL underflow_ret got %0h/%0b want 100/0", ret_a[0], val_a[0]); end
    step(1'b0, 1'b0, 1'b1, 1'b0, 13'h0005);
    n_cmp++; if (err_a[0] !== 1'b0 || st_a[0] !== 1'b1) begin n_fail++; $display("FAIL sticky_hold got %0b/%0b want 0/1", err_a[0], st_a[0]); end
    step(1'b0, 1'b1, 1'b0, 1'b0, 13'd0);
    n_cmp++; if (st_a[0] !== 1'b0 || cnt_a[0] !== 7'd0) begin n_fail++; $display("FAIL flush_clear got %0b/%0d want 0/0", st_a[0], cnt_a[0]); end
  endtask

  task automatic test_full_reject();
    step(1'b0, 1'b1, 1'b0, 1'b0, 13'd0);
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 13'(i));
    n_cmp++; if (err_a[1] !== 1'b1 || cnt_a[1] !== 7'd4 || full_a[1] !== 1'b1) begin n_fail++; $display("FAIL reject_full got err=%0b cnt=%0d full=%0b want 1/4/1", err_a[1], cnt_a[1], full_a[1]); end
    for (int i = 4; i >= 1; i--) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 13'd0);
      n_cmp++; if (ret_a[1] !== 13'(i)) begin n_fail++; $display("FAIL reject_pop got %0h want %0h", ret_a[1], i); end
    end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b1, 1'b0, 1'b0, 13'd0);
    for (int i = 1; i <= 6; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 13'(i));
    n_cmp++; if (err_a[2] !== 1'b0 || cnt_a[2] !== 7'd4) begin n_fail++; $display("FAIL wrap_full got err=%0b cnt=%0d want 0/4", err_a[2], cnt_a[2]); end
    for (int i = 6; i >= 3; i--) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 13'd0);
      n_cmp++; if (ret_a[2] !== 13'(i)) begin n_fail++; $display("FAIL wrap_pop got %0h want %0h", ret_a[2], i); end
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 13'd0);
    n_cmp++; if (err_a[2] !== 1'b1 || val_a[2] !== 1'b0) begin n_fail++; $display("FAIL wrap_underflow got %0b/%0b want 1/0", err_a[2], val_a[2]); end
  endtask

  task automatic test_push_pop();
    step(1'b0, 1'b1, 1'b0, 1'b0, 13'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 13'h0010);
    step(1'b0, 1'b0, 1'b1, 1'b1, 13'h0020);
    n_cmp++; if (ret_a[0] !== 13'h0010 || val_a[0] !== 1'b1) begin n_fail++; $display("FAIL replace_ret got %0h/%0b want 10/1", ret_a[0], val_a[0]); end
    n_cmp++; if (cnt_a[0] !== 7'd1 || top_a[0] !== 13'h0020) begin n_fail++; $display("FAIL replace_top got %0d/%0h want 1/20", cnt_a[0], top_a[0]); end
    step(1'b0, 1'b1, 1'b0, 1'b0, 13'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 13'h0030);
    n_cmp++; if (cnt_a[0] !== 7'd1 || err_a[0] !== 1'b1 || val_a[0] !== 1'b0) begin n_fail++; $display("FAIL pushpop_empty got cnt=%0d err=%0b val=%0b want 1/1/0", cnt_a[0], err_a[0], val_a[0]); end
    n_cmp++; if (top_a[0] !== 13'h0030) begin n_fail++; $display("FAIL pushpop_empty_top got %0h want 30", top_a[0]); end
  endtask

  task automatic test_reset_priority();
    step(1'b0, 1'b1, 1'b0, 1'b0, 13'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 13'h0aa0 + 13'(i));
    step(1'b1, 1'b0, 1'b0, 1'b1, 13'd0);
    n_cmp++; if (ret_a[0] !== 13'd0 || cnt_a[0] !== 7'd0) begin n_fail++; $display("FAIL rst_pop got %0h/%0d want 0/0", ret_a[0], cnt_a[0]); end
    n_cmp++; if (val_a[0] !== 1'b0 || err_a[0] !== 1'b0) begin n_fail++; $display("FAIL rst_pop_flags got %0b/%0b want 0/0", val_a[0], err_a[0]); end
  endtask

  task automatic test_random();
    logic r, f, pu, po;
    int pb, qb;
    for (int n = 0; n < 600; n++) begin
      pb = (n < 200) ? 80 : (n < 400) ? 25 : 50;
      qb = (n < 200) ? 25 : (n < 400) ? 80 : 50;
      r  = (n >= 400) && ($urandom_range(0, 99) < 2);
      f  = (n >= 400) && ($urandom_range(0, 99) < 3);
      pu = ($urandom_range(0, 99) < pb);
      po = ($urandom_range(0, 99) < qb);
      step(r, f, pu, po, 13'($urandom));
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (ret_a[k] !== mret[k] || val_a[k] !== mval[k] || cnt_a[k] !== 7'(mc[k])
            || top_a[k] !== ((mc[k] > 0) ? ms[k][mc[k]-1] : 13'd0)
            || full_a[k] !== (mc[k] == mdepth[k]) || empty_a[k] !== (mc[k] == 0)
            || err_a[k] !== merr[k] || st_a[k] !== mst[k]) begin
          n_fail++;
          $display("FAIL random[%0d] inst%0d got ret=%0h v=%0b cnt=%0d top=%0h e=%0b s=%0b want ret=%0h v=%0b cnt=%0d e=%0b s=%0b",
                   n, k, ret_a[k], val_a[k], cnt_a[k], top_a[k], err_a[k], st_a[k],
                   mret[k], mval[k], mc[k], merr[k], mst[k]);
        end
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_lifo();
    test_error();
    test_full_reject();
    test_wrap();
    test_push_pop();
    test_reset_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
